sut_sequencer: RTL
==================

# sut_sequencer

Timing and run-control sequencer for the 16-QAM system-under-test chain (mapper → pulse-shaping filter → matched filter → decision register). It derives the sample-rate and symbol-rate enables from `sys_clk`, gates zero-stuffed data insertion into the pulse filter, and picks the decision-sampling phase within each symbol. It also switches the transmit-filter selection only on symbol boundaries. A start/stop state machine flushes the filters with zeros before live data and drains them after data ends.

## Interface
- `SAM_DIV`, 4: `sys_clk` cycles per sample; legal range 2..256.
- `SPS`, 4: samples per symbol; legal range 2..16.
- `FLUSH_SYMS`, 8: symbols of zero input in the FLUSH and DRAIN states; legal range 1..255.
- `sys_clk` in 1: single system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: run request; sampled every cycle.
- `stop` in 1: stop request; sampled every cycle.
- `sw_sel` in 1: requested filter; 1 = gold-standard pulse, 0 = practical pulse.
- `dec_phase` in 4: sample index within a symbol at which the decision is taken.
- `sam_clk_ena` out 1: one-cycle sample-rate strobe.
- `sym_clk_ena` out 1: one-cycle symbol-rate strobe.
- `sample_phase` out 4: current sample index within the symbol, 0..SPS-1.
- `insert_ena` out 1: level; high while mapper data may enter the filter; low means the filter input is zero-stuffed.
- `decision_ena` out 1: one-cycle strobe to load the decision register.
- `filter_sel` out 1: registered filter select that drives the pulse-filter mux.
- `state` out 2: 0 IDLE, 1 FLUSH, 2 RUN, 3 DRAIN.
- `sym_count` out 16: number of symbols issued in RUN.

## Operation
- **Reset:** state = IDLE. All counters are 0. All outputs are 0, including `filter_sel`.
- **Counters:** `div_cnt` runs 0..SAM_DIV-1 in every state except IDLE; it is held at 0 in IDLE.
  - `sam_clk_ena` is high exactly in the cycles where `div_cnt` = SAM_DIV-1.
  - `sample_phase` advances on `sam_clk_ena` and wraps from SPS-1 to 0.
  - `sym_clk_ena` equals `sam_clk_ena` AND (`sample_phase` = SPS-1).
- **Decision phase:** `dec_phase` is captured on the IDLE→FLUSH transition. A captured value ≥ SPS is clamped to SPS-1.
  - In RUN and DRAIN, `decision_ena` equals `sam_clk_ena` AND (`sample_phase` = captured phase).
  - `decision_ena` is 0 in IDLE and FLUSH.
- **Data insertion:** `insert_ena` is 1 only in RUN while `sample_phase` = 0.
- **Filter select:** in IDLE, `filter_sel` follows `sw_sel` with 1-cycle latency. In every other state it updates from `sw_sel` only on `sym_clk_ena` cycles.
- **Symbol count:** `sym_count` clears on IDLE→FLUSH. It increments on each `sym_clk_ena` while in RUN and wraps from 65535 to 0.
- **FSM:**
  - IDLE → FLUSH when `start`=1 and `stop`=0. If `start` and `stop` are both 1, the block stays in IDLE.
  - FLUSH → RUN on the FLUSH_SYMS-th `sym_clk_ena`.
  - FLUSH → IDLE if a `stop` has been seen during FLUSH. The transition takes effect at the next `sym_clk_ena` (abort).
  - RUN → DRAIN at the first `sym_clk_ena` at or after a `stop` pulse. The `stop` is latched, so a 1-cycle pulse is sufficient.
  - DRAIN → IDLE on the FLUSH_SYMS-th `sym_clk_ena` in DRAIN.
  - `start` is ignored outside IDLE. `stop` is ignored in DRAIN and IDLE.
- **Mid-operation reset:** `reset` in any state returns the block to IDLE on the next edge. No strobe may fire in the cycle after `reset` was sampled high.

## Timing
- Each strobe (`sam_clk_ena`, `sym_clk_ena`, `decision_ena`) is exactly 1 `sys_clk` cycle wide and comes straight from a register output, with no combinational decode at the ports.
- The first FLUSH cycle (the one after `start` is sampled) has `div_cnt` = 0. The first `sam_clk_ena` falls in the SAM_DIV-th FLUSH cycle.
- The first `sym_clk_ena` falls in FLUSH cycle SAM_DIV·SPS.
- `state` changes in the cycle after the qualifying `sym_clk_ena`. The counters do not restart at state changes between FLUSH, RUN and DRAIN; strobe spacing stays exactly SAM_DIV and SAM_DIV·SPS.
- `insert_ena` rises in the first RUN cycle. It is high for SAM_DIV cycles per symbol.

## Test plan
- **Reset values:** defaults, `reset` held 3 cycles → all outputs 0 and `state`=0. Then `start` pulse → `sam_clk_ena` at FLUSH cycles 4, 8, 12, …; `sym_clk_ena` at cycles 16, 32, …; `state`=2 from cycle 129.
- **RUN cadence:** in RUN with `dec_phase`=2 → `insert_ena` high for cycles 0-3 of each 16-cycle symbol. `decision_ena` coincides with the 3rd `sam_clk_ena` of each symbol. `sym_count` reaches 10 after 10 symbols.
- **Clamp:** `dec_phase`=9 with SPS=4 → `decision_ena` on the `sym_clk_ena` cycle.
- **Filter switch:** toggle `sw_sel` mid-symbol in RUN → `filter_sel` changes only in the cycle after the next `sym_clk_ena`.
- **Stop paths:** 1-cycle `stop` in RUN → DRAIN at the next symbol boundary; `insert_ena` stays 0; IDLE after 8 symbols; `decision_ena` continues through DRAIN. `stop` during FLUSH → IDLE at the next symbol boundary, with no RUN state seen.
- **Edge cases:** `start` and `stop` together in IDLE → stays IDLE. `reset` asserted mid-RUN → IDLE on the next edge and no strobes in the following cycle. `sym_count` preloaded near 65535 by running 65536 symbols → wraps to 0.

Source files
------------

// File: rtl/sut_sequencer.sv
// sut_sequencer: timing and run-control sequencer for the 16-QAM SUT chain.
// It derives the sample and symbol strobes, gates data insertion and picks the
// decision phase. It also switches the pulse filter only on symbol boundaries.
// Every strobe is a register output. Each one is loaded from the next-cycle
// values of the counters and the state.
module sut_sequencer #(
  parameter int SAM_DIV    = 4,
  parameter int SPS        = 4,
  parameter int FLUSH_SYMS = 8
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        sw_sel,
  input  logic [3:0]  dec_phase,
  output logic        sam_clk_ena,
  output logic        sym_clk_ena,
  output logic [3:0]  sample_phase,
  output logic        insert_ena,
  output logic        decision_ena,
  output logic        filter_sel,
  output logic [1:0]  state,
  output logic [15:0] sym_count
);

  localparam int DW = $clog2(SAM_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAM_DIV - 1);
  localparam logic [3:0]    PH_LAST  = 4'(SPS - 1);
  localparam logic [7:0]    FL_LAST  = 8'(FLUSH_SYMS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        cur_st;
  state_t        nxt_st;
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic [3:0]    phase_nxt;
  logic [3:0]    cap_phase;
  logic [7:0]    sym_in_state;
  logic          stop_seen;
  logic          stop_eff;
  logic          sam_nxt;
  logic          sym_nxt;
  logic          dec_nxt;
  logic          ins_nxt;

  assign state = cur_st;

  // Next state, next counter values and the strobe values for the next cycle
  always_comb begin
    nxt_st    = cur_st;
    stop_eff  = stop_seen | stop;
    div_nxt   = '0;
    phase_nxt = sample_phase;
    sam_nxt   = 1'b0;
    sym_nxt   = 1'b0;
    dec_nxt   = 1'b0;
    ins_nxt   = 1'b0;

    case (cur_st)
      IDLE: begin
        if (start && !stop) nxt_st = FLUSH;
      end
      FLUSH: begin
        if (sym_clk_ena) begin
          if (stop_eff) nxt_st = IDLE;
          else if (sym_in_state == FL_LAST) nxt_st = RUN;
        end
      end
      RUN: begin
        if (sym_clk_ena && stop_eff) nxt_st = DRAIN;
      end
      DRAIN: begin
        if (sym_clk_ena && sym_in_state == FL_LAST) nxt_st = IDLE;
      end
      default: nxt_st = IDLE;
    endcase

    if (nxt_st == IDLE || cur_st == IDLE) div_nxt = '0;
    else if (div_cnt == DIV_LAST) div_nxt = '0;
    else div_nxt = div_cnt + DW'(1);

    if (nxt_st == IDLE) phase_nxt = 4'd0;
    else if (sam_clk_ena) phase_nxt = (sample_phase == PH_LAST) ? 4'd0 : sample_phase + 4'd1;

    sam_nxt = (nxt_st != IDLE) && (div_nxt == DIV_LAST);
    sym_nxt = sam_nxt && (phase_nxt == PH_LAST);
    dec_nxt = (nxt_st == RUN || nxt_st == DRAIN) && sam_nxt && (phase_nxt == cap_phase);
    ins_nxt = (nxt_st == RUN) && (phase_nxt == 4'd0);
  end

  // State register, counters, strobe registers and run bookkeeping
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cur_st       <= IDLE;
      div_cnt      <= '0;
      sample_phase <= 4'd0;
      sam_clk_ena  <= 1'b0;
      sym_clk_ena  <= 1'b0;
      decision_ena <= 1'b0;
      insert_ena   <= 1'b0;
      filter_sel   <= 1'b0;
      cap_phase    <= 4'd0;
      sym_in_state <= 8'd0;
      stop_seen    <= 1'b0;
      sym_count    <= 16'd0;
    end else begin
      cur_st       <= nxt_st;
      div_cnt      <= div_nxt;
      sample_phase <= phase_nxt;
      sam_clk_ena  <= sam_nxt;
      sym_clk_ena  <= sym_nxt;
      decision_ena <= dec_nxt;
      insert_ena   <= ins_nxt;

      if (cur_st == IDLE || sym_clk_ena) filter_sel <= sw_sel;

      if (cur_st == IDLE && nxt_st == FLUSH)
        cap_phase <= (dec_phase > PH_LAST) ? PH_LAST : dec_phase;

      if (nxt_st != cur_st) sym_in_state <= 8'd0;
      else if (sym_clk_ena && (cur_st == FLUSH || cur_st == DRAIN))
        sym_in_state <= sym_in_state + 8'd1;

      if (nxt_st != cur_st) stop_seen <= 1'b0;
      else if (stop && (cur_st == FLUSH || cur_st == RUN)) stop_seen <= 1'b1;

      if (cur_st == IDLE && nxt_st == FLUSH) sym_count <= 16'd0;
      else if (cur_st == RUN && sym_clk_ena) sym_count <= sym_count + 16'd1;
    end
  end

endmodule
